// File: rtl/dma_arb_pkg.sv
// Shared definitions for the DMA request arbiter: FSM state encoding and
// default channel-count constants.
package dma_arb_pkg;

    localparam int NCH_DEF = 4;
    localparam int CW_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARB   = 2'b01,
        GRANT = 2'b10,
        DONE  = 2'b11
    } arb_state_e;

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational round-robin picker: returns the index of the first set bit of
// req_i at or above ptr_i, wrapping modulo NCH. vld_o is low when req_i is empty.
module dma_rr_pick #(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic [NCH-1:0] req_i,
    input  logic [CW-1:0]  ptr_i,
    output logic [CW-1:0]  idx_o,
    output logic           vld_o
);

    localparam logic [CW:0] NCH_W = (CW+1)'(NCH);

    logic [CW:0]   sum;
    logic [CW-1:0] cand;

    // Walk the NCH candidates in priority order; the first hit wins.
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NCH; i++) begin
            // ptr_i < NCH and i < NCH, so one conditional subtract wraps the sum
            sum = {1'b0, ptr_i} + (CW+1)'(i);
            if (sum >= NCH_W) begin
                sum = sum - NCH_W;
            end
            cand = sum[CW-1:0];
            if (!vld_o && req_i[cand]) begin
                idx_o = cand;
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_req_arb.sv
// Round-robin arbiter sharing the AHB DMA master between NCH channel request
// machines. One transfer is granted at a time; the grant is held until the
// master's m_done pulse, the winner then gets a one-cycle ch_req_done pulse and
// the round-robin pointer moves just past it.
// Optional build macro DMA_ARB_WRPRIO_EN: pending writes are always served
// before any read (round-robin among writes first, then among all requests).
module dma_req_arb
    import dma_arb_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic           hclk,
    input  logic           hreset,
    input  logic           arb_en,
    input  logic [NCH-1:0] ch_rd_req,
    input  logic [NCH-1:0] ch_wr_req,
    output logic [NCH-1:0] ch_req_done,
    output logic [NCH-1:0] grant,
    output logic           m_req,
    output logic           m_wr,
    output logic [CW-1:0]  m_ch,
    input  logic           m_done,
    output logic           busy
);

    localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

    arb_state_e     state_q;
    logic [CW-1:0]  rr_ptr_q;
    logic [CW-1:0]  rr_ptr_d;
    logic [CW-1:0]  m_ch_q;
    logic           m_wr_q;
    logic           m_req_q;
    logic [NCH-1:0] grant_q;
    logic [NCH-1:0] done_q;

    logic [NCH-1:0] pending;
    logic [CW-1:0]  win_idx;
    logic           win_vld;
    logic           win_wr;

    function automatic logic [NCH-1:0] ch_onehot(input logic [CW-1:0] ch);
        ch_onehot     = '0;
        ch_onehot[ch] = 1'b1;
    endfunction

    assign pending = ch_rd_req | ch_wr_req;

`ifdef DMA_ARB_WRPRIO_EN
    logic [CW-1:0] wr_idx;
    logic          wr_vld;
    logic [CW-1:0] all_idx;
    logic          all_vld;

    dma_rr_pick #(.NCH(NCH), .CW(CW)) u_pick_wr (
        .req_i (ch_wr_req),
        .ptr_i (rr_ptr_q),
        .idx_o (wr_idx),
        .vld_o (wr_vld)
    );

    dma_rr_pick #(.NCH(NCH), .CW(CW)) u_pick_all (
        .req_i (pending),
        .ptr_i (rr_ptr_q),
        .idx_o (all_idx),
        .vld_o (all_vld)
    );

    // Any pending write-back takes precedence over every read.
    assign win_idx = wr_vld ? wr_idx : all_idx;
    assign win_vld = wr_vld | all_vld;
`else
    dma_rr_pick #(.NCH(NCH), .CW(CW)) u_pick (
        .req_i (pending),
        .ptr_i (rr_ptr_q),
        .idx_o (win_idx),
        .vld_o (win_vld)
    );
`endif

    // A channel holding both requests is served as a write first.
    assign win_wr = ch_wr_req[win_idx];

    // Next round-robin start: one past the channel just served, wrapping.
    always_comb begin
        rr_ptr_d = (m_ch_q == LAST_CH) ? '0 : m_ch_q + CW'(1);
    end

    // Arbitration FSM with registered master-side and channel-side outputs.
    always_ff @(posedge hclk or negedge hreset) begin
        if (!hreset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            m_ch_q   <= '0;
            m_wr_q   <= 1'b0;
            m_req_q  <= 1'b0;
            grant_q  <= '0;
            done_q   <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (arb_en && (|pending)) begin
                        state_q <= ARB;
                    end
                end
                ARB: begin
                    if (!arb_en || !win_vld) begin
                        state_q <= IDLE;
                    end else begin
                        m_ch_q  <= win_idx;
                        m_wr_q  <= win_wr;
                        m_req_q <= 1'b1;
                        grant_q <= ch_onehot(win_idx);
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    // Request drops and arb_en are deliberately ignored here:
                    // a started transfer always runs to m_done.
                    if (m_done) begin
                        m_req_q  <= 1'b0;
                        grant_q  <= '0;
                        done_q   <= ch_onehot(m_ch_q);
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    // Always re-arbitrate one cycle later so the served
                    // channel has time to drop its request.
                    state_q <= arb_en ? ARB : IDLE;
                end
            endcase
        end
    end

    assign m_req       = m_req_q;
    assign m_wr        = m_wr_q;
    assign m_ch        = m_ch_q;
    assign grant       = grant_q;
    assign ch_req_done = done_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dma_req_arb.sv
// Self-checking bench for dma_req_arb: directed vectors, corner-case
// sequences and a randomized run against a transaction-level model.
module tb_dma_req_arb;

    localparam int NCH = 4;
    localparam int CW  = 2;

    logic           hclk;
    logic           hreset;
    logic           arb_en;
    logic [NCH-1:0] ch_rd_req;
    logic [NCH-1:0] ch_wr_req;
    logic [NCH-1:0] ch_req_done;
    logic [NCH-1:0] grant;
    logic           m_req;
    logic           m_wr;
    logic [CW-1:0]  m_ch;
    logic           m_done;
    logic           busy;

    int n_total = 0;
    int n_pass  = 0;

    dma_req_arb #(.NCH(NCH), .CW(CW)) dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .arb_en      (arb_en),
        .ch_rd_req   (ch_rd_req),
        .ch_wr_req   (ch_wr_req),
        .ch_req_done (ch_req_done),
        .grant       (grant),
        .m_req       (m_req),
        .m_wr        (m_wr),
        .m_ch        (m_ch),
        .m_done      (m_done),
        .busy        (busy)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int onehot(input int ch);
        return (ch < 0) ? 0 : (1 << ch);
    endfunction

    // Reference: first requesting channel scanning upward from ptr, modulo NCH.
    function automatic int model_pick(input logic [NCH-1:0] rd, input logic [NCH-1:0] wr,
                                      input int ptr, output bit w);
        logic [NCH-1:0] pool;
        pool = rd | wr;
`ifdef DMA_ARB_WRPRIO_EN
        if (wr != '0) pool = wr;
`endif
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (ptr + k) % NCH;
            if (pool[c]) begin
                w = wr[c];
                return c;
            end
        end
        w = 1'b0;
        return -1;
    endfunction

    task automatic do_reset();
        hreset    = 1'b0;
        arb_en    = 1'b1;
        ch_rd_req = '0;
        ch_wr_req = '0;
        m_done    = 1'b0;
        repeat (2) @(negedge hclk);
        hreset = 1'b1;
    endtask

    task automatic wait_mreq(input string nm);
        int n;
        n = 0;
        while (!m_req && n < 12) begin
            @(negedge hclk);
            n++;
        end
        if (!m_req) check({nm, "_timeout"}, int'(m_req), 1);
    endtask

    // Called at a negedge with m_req high: pulse m_done, expect one done pulse.
    task automatic finish_xfer(input string nm, input int ch);
        m_done = 1'b1;
        @(negedge hclk);
        m_done = 1'b0;
        check({nm, "_done"}, int'(ch_req_done), onehot(ch));
        check({nm, "_mreq_low"}, int'(m_req), 0);
        @(negedge hclk);
        check({nm, "_done_1cyc"}, int'(ch_req_done), 0);
    endtask

    typedef struct {
        int             pre;
        logic [NCH-1:0] rd;
        logic [NCH-1:0] wr;
        int             ch_rr;
        bit             wr_rr;
        int             ch_wp;
        bit             wr_wp;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int  ec;
        bit  ew;
        int  exp_seq [5];
        int  ptr_m, cur_ch, hold, stall;
        bit  cur_wr, in_grant, done_due;

        tbl[0] = '{-1, 4'b0100, 4'b0000, 2, 1'b0, 2, 1'b0};
        tbl[1] = '{-1, 4'b1111, 4'b0000, 0, 1'b0, 0, 1'b0};
        tbl[2] = '{ 0, 4'b0001, 4'b0000, 0, 1'b0, 0, 1'b0};
        tbl[3] = '{ 1, 4'b0011, 4'b1000, 3, 1'b1, 3, 1'b1};
        tbl[4] = '{ 3, 4'b1010, 4'b0000, 1, 1'b0, 1, 1'b0};
        tbl[5] = '{-1, 4'b0001, 4'b1000, 0, 1'b0, 3, 1'b1};
        tbl[6] = '{ 2, 4'b0110, 4'b0001, 0, 1'b1, 0, 1'b1};
        tbl[7] = '{ 0, 4'b0001, 4'b0001, 0, 1'b1, 0, 1'b1};
        tbl[8] = '{ 1, 4'b0100, 4'b0010, 2, 1'b0, 1, 1'b1};

        // Reset state
        hreset = 1'b0; arb_en = 1'b1; ch_rd_req = 4'b1111; ch_wr_req = 4'b1111; m_done = 1'b0;
        repeat (3) @(negedge hclk);
        check("rst_mreq", int'(m_req), 0);
        check("rst_grant", int'(grant), 0);
        check("rst_done", int'(ch_req_done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_mch", int'(m_ch), 0);
        check("rst_mwr", int'(m_wr), 0);

        // Single read: latency and rr pointer advance
        do_reset();
        ch_rd_req = 4'b0100;
        @(negedge hclk);
        check("lat_busy_arb", int'(busy), 1);
        check("lat_mreq_arb", int'(m_req), 0);
        @(negedge hclk);
        check("lat_mreq", int'(m_req), 1);
        check("lat_mch", int'(m_ch), 2);
        check("lat_mwr", int'(m_wr), 0);
        check("lat_grant", int'(grant), 4'b0100);
        finish_xfer("single", 2);
        ch_rd_req = 4'b1001;
        wait_mreq("ptr3");
        check("ptr3_mch", int'(m_ch), 3);
        finish_xfer("ptr3", 3);

        // Round robin with all channels holding requests
        do_reset();
        exp_seq = '{0, 1, 2, 3, 0};
        ch_rd_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_mreq("rr");
            check("rr_mch", int'(m_ch), exp_seq[g]);
            repeat (2) @(negedge hclk);
            check("rr_mch_stable", int'(m_ch), exp_seq[g]);
            finish_xfer("rr", exp_seq[g]);
        end

        // Same-channel read and write
        do_reset();
        ch_rd_req = 4'b0001; ch_wr_req = 4'b0001;
        wait_mreq("rdwr");
        check("rdwr_mch", int'(m_ch), 0);
        check("rdwr_mwr", int'(m_wr), 1);
        finish_xfer("rdwr", 0);
        ch_wr_req = 4'b0000;
        wait_mreq("rdwr2");
        check("rdwr2_mch", int'(m_ch), 0);
        check("rdwr2_mwr", int'(m_wr), 0);
        finish_xfer("rdwr2", 0);

        // arb_en dropped during a grant
        do_reset();
        ch_rd_req = 4'b1010;
        wait_mreq("en");
        check("en_mch", int'(m_ch), 1);
        arb_en = 1'b0;
        @(negedge hclk);
        check("en_hold_mreq", int'(m_req), 1);
        finish_xfer("en", 1);
        ch_rd_req = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            check("en_idle_busy", int'(busy), 0);
            check("en_idle_mreq", int'(m_req), 0);
            @(negedge hclk);
        end
        arb_en = 1'b1;
        wait_mreq("en_resume");
        check("en_resume_mch", int'(m_ch), 3);
        finish_xfer("en_resume", 3);

        // Asynchronous reset in the middle of a grant
        do_reset();
        ch_rd_req = 4'b0010;
        wait_mreq("ar_pre");
        finish_xfer("ar_pre", 1);
        ch_rd_req = 4'b0110;
        wait_mreq("ar");
        check("ar_mch", int'(m_ch), 2);
        #2 hreset = 1'b0;
        #1;
        check("ar_mreq", int'(m_req), 0);
        check("ar_grant", int'(grant), 0);
        check("ar_done", int'(ch_req_done), 0);
        check("ar_busy", int'(busy), 0);
        @(negedge hclk);
        hreset = 1'b1;
        wait_mreq("ar_post");
        check("ar_post_mch", int'(m_ch), 1);
        finish_xfer("ar_post", 1);

        // Read on ch0 against write on ch3 from rr_ptr=0
        do_reset();
        ch_rd_req = 4'b0001; ch_wr_req = 4'b1000;
        wait_mreq("wp1");
`ifdef DMA_ARB_WRPRIO_EN
        check("wp1_mch", int'(m_ch), 3);
        check("wp1_mwr", int'(m_wr), 1);
        finish_xfer("wp1", 3);
        ch_wr_req = 4'b0000;
        wait_mreq("wp2");
        check("wp2_mch", int'(m_ch), 0);
        check("wp2_mwr", int'(m_wr), 0);
        finish_xfer("wp2", 0);
`else
        check("wp1_mch", int'(m_ch), 0);
        check("wp1_mwr", int'(m_wr), 0);
        finish_xfer("wp1", 0);
        ch_rd_req = 4'b0000;
        wait_mreq("wp2");
        check("wp2_mch", int'(m_ch), 3);
        check("wp2_mwr", int'(m_wr), 1);
        finish_xfer("wp2", 3);
`endif

        // Table-driven first-grant vectors, optionally after a priming transfer
        for (int v = 0; v < 9; v++) begin
            do_reset();
            if (tbl[v].pre >= 0) begin
                ch_rd_req = NCH'(onehot(tbl[v].pre));
                wait_mreq("tbl_pre");
                check("tbl_pre_mch", int'(m_ch), tbl[v].pre);
                finish_xfer("tbl_pre", tbl[v].pre);
            end
            ch_rd_req = tbl[v].rd;
            ch_wr_req = tbl[v].wr;
            wait_mreq("tbl");
`ifdef DMA_ARB_WRPRIO_EN
            check($sformatf("tbl%0d_mch", v), int'(m_ch), tbl[v].ch_wp);
            check($sformatf("tbl%0d_mwr", v), int'(m_wr), int'(tbl[v].wr_wp));
            check($sformatf("tbl%0d_grant", v), int'(grant), onehot(tbl[v].ch_wp));
`else
            check($sformatf("tbl%0d_mch", v), int'(m_ch), tbl[v].ch_rr);
            check($sformatf("tbl%0d_mwr", v), int'(m_wr), int'(tbl[v].wr_rr));
            check($sformatf("tbl%0d_grant", v), int'(grant), onehot(tbl[v].ch_rr));
`endif
        end

        // Randomized traffic against the transaction-level model
        do_reset();
        ptr_m = 0; cur_ch = 0; cur_wr = 1'b0; hold = 0; stall = 0;
        in_grant = 1'b0; done_due = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge hclk);
            if (done_due) begin
                check("rnd_done", int'(ch_req_done), onehot(cur_ch));
                check("rnd_done_mreq", int'(m_req), 0);
                ptr_m = (cur_ch + 1) % NCH;
                if (cur_wr) ch_wr_req[cur_ch] = 1'b0;
                else        ch_rd_req[cur_ch] = 1'b0;
                in_grant = 1'b0;
                done_due = 1'b0;
            end else begin
                check("rnd_no_done", int'(ch_req_done), 0);
                if (m_req && !in_grant) begin
                    ec = model_pick(ch_rd_req, ch_wr_req, ptr_m, ew);
                    check("rnd_mch", int'(m_ch), ec);
                    check("rnd_mwr", int'(m_wr), int'(ew));
                    check("rnd_grant", int'(grant), onehot(ec));
                    cur_ch   = (ec < 0) ? int'(m_ch) : ec;
                    cur_wr   = (ec < 0) ? m_wr : ew;
                    in_grant = 1'b1;
                    hold     = $urandom_range(0, 5);
                end else if (in_grant) begin
                    check("rnd_hold_mreq", int'(m_req), 1);
                    check("rnd_hold_mch", int'(m_ch), cur_ch);
                    check("rnd_hold_grant", int'(grant), onehot(cur_ch));
                end
            end
            if (!in_grant && ((ch_rd_req | ch_wr_req) != '0)) stall++;
            else stall = 0;
            if (stall > 4) begin
                check("rnd_stall", stall, 0);
                stall = 0;
            end
            m_done = 1'b0;
            if (in_grant && m_req && !done_due) begin
                if (hold == 0) begin
                    m_done   = 1'b1;
                    done_due = 1'b1;
                end else begin
                    hold--;
                end
            end else if (!in_grant && $urandom_range(0, 7) == 0) begin
                m_done = 1'b1;
            end
            for (int i = 0; i < NCH; i++) begin
                if (!ch_rd_req[i] && !ch_wr_req[i] && $urandom_range(0, 3) == 0) begin
                    int r;
                    r = $urandom_range(1, 3);
                    ch_rd_req[i] = r[0];
                    ch_wr_req[i] = r[1];
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
